// File: rtl/ds_pkg.sv
// ds_pkg: request codes and engine state encoding shared with the command sequencer
package ds_pkg;
  localparam logic [1:0] FUNC_IDLE  = 2'b00;
  localparam logic [1:0] FUNC_READ  = 2'b01;
  localparam logic [1:0] FUNC_WRITE = 2'b10;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RECOVER, DONE} ds_state_e;
endpackage

// File: rtl/ds_function.sv
// ds_function: DS1302 3-wire serial engine, one 16-clock transfer per request
module ds_function
  import ds_pkg::*;
#(
  parameter int HALF_CYC = 25,
  parameter int CE_CYC   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] func_start,
  input  logic [7:0] register_addr,
  input  logic [7:0] write_data,
  output logic       func_done,
  output logic [7:0] read_data,
  output logic       rtc_rst,
  output logic       rtc_sclk,
  inout  wire        rtc_sio
);
  localparam int MAXC = HALF_CYC > CE_CYC ? HALF_CYC : CE_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CE_CYC);
  localparam logic [CW-1:0] CE_LAST = CW'(CE_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  ds_state_e state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [3:0] bit_cnt, nbit;
  logic hi, nhi, wr, start, sio_oe, sio_out, sample;
  logic [7:0] addr, wdata, shreg, cur_addr, cur_wdata;
  assign start = func_start == FUNC_WRITE || func_start == FUNC_READ;
  assign cur_addr = state == IDLE ? register_addr : addr;
  assign cur_wdata = state == IDLE ? write_data : wdata;
  assign sample = state == SHIFT && !hi && cnt == HALF_LAST && bit_cnt[3];
  assign rtc_sio = sio_oe ? sio_out : 1'bz;
  // SETUP runs one extra cycle so CE rises one edge after acceptance yet stays high CE_CYC cycles
  always_comb begin
    nstate = state;
    ncnt = cnt + 1'b1;
    nbit = bit_cnt;
    nhi = hi;
    case (state)
      IDLE: begin
        ncnt = '0;
        nbit = '0;
        nhi = 1'b0;
        if (start) nstate = SETUP;
      end
      SETUP: if (cnt == SETUP_LAST) begin
        nstate = SHIFT;
        ncnt = '0;
      end
      SHIFT: if (cnt == HALF_LAST) begin
        ncnt = '0;
        nhi = !hi;
        if (hi) begin
          if (bit_cnt == 4'd15) nstate = HOLD;
          else nbit = bit_cnt + 4'd1;
        end
      end
      HOLD: if (cnt == CE_LAST) begin
        nstate = RECOVER;
        ncnt = '0;
      end
      RECOVER: if (cnt == CE_LAST) begin
        nstate = DONE;
        ncnt = '0;
      end
      default: begin
        nstate = IDLE;
        ncnt = '0;
      end
    endcase
  end
  // pin registers are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      hi <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      shreg <= '0;
      read_data <= '0;
      func_done <= 1'b0;
      rtc_rst <= 1'b0;
      rtc_sclk <= 1'b0;
      sio_oe <= 1'b0;
      sio_out <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      bit_cnt <= nbit;
      hi <= nhi;
      if (state == IDLE && start) begin
        addr <= register_addr;
        wdata <= write_data;
        wr <= func_start == FUNC_WRITE;
      end
      if (sample) shreg <= {rtc_sio, shreg[7:1]};
      if (nstate == DONE && !wr) read_data <= shreg;
      func_done <= nstate == DONE;
      rtc_rst <= state != IDLE && (nstate == SETUP || nstate == SHIFT || nstate == HOLD);
      rtc_sclk <= nstate == SHIFT && nhi;
      sio_oe <= nstate == SETUP || (nstate == SHIFT && (wr || !nbit[3])) || (nstate == HOLD && wr);
      sio_out <= nbit[3] ? cur_wdata[nbit[2:0]] : cur_addr[nbit[2:0]];
    end
  end
endmodule

// File: doc/ds_function.md
# ds_function

Bit-level serial engine for the DS1302 3-wire interface (CE, SCLK, bidirectional I/O). It sits directly downstream of the command sequencer. It accepts one write or read request on `func_start` with a register address and write byte, and drives one complete 16-clock DS1302 transfer on the pins. It returns a one-cycle `func_done` and, for reads, the received byte on `read_data`.

## Interface
Parameters:
- `HALF_CYC`, default 25: clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz); must be ≥ 2.
- `CE_CYC`, default 200: clk cycles each for CE setup, CE hold and CE inactive recovery (4 µs at 50 MHz); must be ≥ 1.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `func_start` in 2: `2'b10` = write, `2'b01` = read, `2'b00`/`2'b11` = no request.
- `register_addr` in 8: DS1302 command byte, sent verbatim, LSB first.
- `write_data` in 8: data byte for writes.
- `func_done` out 1: one-cycle pulse when the transfer, including recovery, is complete.
- `read_data` out 8: last byte read; holds its value between reads.
- `rtc_rst` out 1: DS1302 CE pin.
- `rtc_sclk` out 1: DS1302 SCLK pin.
- `rtc_sio` inout 1: DS1302 I/O pin; driven when the internal `sio_oe` is 1, high-Z otherwise.

## Operation
- States: `IDLE`, `SETUP`, `SHIFT`, `HOLD`, `RECOVER`, `DONE`.
- `IDLE`
  - Acceptance: `func_start` of `2'b10` or `2'b01` is accepted on a clock edge.
  - Latching: `register_addr`, `write_data` and the direction are latched on that edge, then the block enters `SETUP`.
  - No request: `2'b00` and `2'b11` are ignored.
- After acceptance, all inputs are ignored until the block is back in `IDLE`.
- `SETUP` (`CE_CYC` cycles)
  - `rtc_rst`=1, `rtc_sclk`=0.
  - `sio_oe`=1, driving addr bit 0.
- `SHIFT`: 16 SCLK pulses, n = 0..15. Each pulse is a low phase of `HALF_CYC` cycles followed by a high phase of `HALF_CYC` cycles.
  - Pulses 0–7: addr bit n is driven from the first cycle of the low phase.
  - Write, pulses 8–15: `write_data` bit (n−8) is driven from the first cycle of the low phase.
  - Read, pulses 8–15:
    - `sio_oe` drops to 0 at the first cycle of pulse 8's low phase.
    - Input bit (n−8) is sampled on the last cycle of pulse n's low phase.
    - Samples fill a shift register LSB first.
- `HOLD` (`CE_CYC` cycles)
  - `rtc_rst`=1, `rtc_sclk`=0.
  - I/O stays driven for a write and released for a read.
- `RECOVER` (`CE_CYC` cycles): `rtc_rst`=0, `sio_oe`=0.
- `DONE` (1 cycle)
  - `func_done`=1.
  - On a read, `read_data` loads the shift register on entry to `DONE`.
  - Next state is `IDLE`. A request still present in that `IDLE` cycle starts a new transfer, so there is at least one `IDLE` cycle between transfers.
- Direction comes from `func_start` only. `register_addr[0]` is not interpreted.
- A write never modifies `read_data`.
- Counters:
  - Phase counter width is `$clog2(max(HALF_CYC, CE_CYC)+1)`.
  - Bit counter is 4 bits and counts 0..15 with no wrap beyond 15.
- Reset values: `func_done`=0, `read_data`=8'h00, `rtc_rst`=0, `rtc_sclk`=0, `sio_oe`=0, state=`IDLE`.
- Reset asserted mid-transfer forces all of the above immediately (asynchronously) and discards the latched request.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `rtc_rst` rises on the first clock edge after the accepting edge.
- CE high time is exactly `2*CE_CYC + 32*HALF_CYC` cycles.
- `func_done` rises exactly `3*CE_CYC + 32*HALF_CYC` cycles after `rtc_rst` rises. With defaults that is 1400 cycles.
- Handshake with the upstream sequencer: it drops `func_start` in the cycle after `func_done`. That cycle is this block's `IDLE` cycle, so no spurious restart occurs.
- I/O changes only while `rtc_sclk`=0, at least `HALF_CYC` cycles before each rising edge.

## Structure
- Shared package `ds_pkg`: `FUNC_IDLE`=2'b00, `FUNC_READ`=2'b01, `FUNC_WRITE`=2'b10, and the state encoding. The command sequencer uses the same constants.
- No sub-module. The single tri-state assignment for `rtc_sio` lives in this block.

## Test plan
All scenarios use `HALF_CYC`=2 and `CE_CYC`=4 unless stated.
- Reset: assert `rst_n`=0 mid-`SHIFT` at pulse 5 → `rtc_rst`/`rtc_sclk`/`func_done`=0, `rtc_sio` high-Z and `read_data`=0 at once. A subsequent write completes normally.
- Write: `func_start`=10, addr 8'h8E, data 8'h00 → the DS1302 model captures 0x8E then 0x00 LSB first on 16 rising edges. `func_done` pulses once, 76 cycles after CE rises; `read_data` is unchanged.
- Read: `func_start`=01, addr 8'h81, model returns 0x59 → `sio_oe`=0 from pulse 8. `read_data`=8'h59 coincident with `func_done`, held afterwards.
- Handshake: upstream drops `func_start` the cycle after `func_done` → no second transfer. Holding `func_start`=01 → a second read starts after exactly one `IDLE` cycle.
- Illegal/changing input: `func_start`=11 → no CE activity. Changing `register_addr` to 8'h85 mid-`SHIFT` → the transfer still sends 0x81.
- Defaults: `HALF_CYC`=25, `CE_CYC`=200 → SCLK period of 50 cycles, CE high 1200 cycles, `func_done` 1400 cycles after CE rises.
